// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the sensor-interface I2C master.
package iot_sensor_pkg;

    // Transaction sequencer states of the single-byte I2C master
    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_NACK,
        STOP,
        DONE
    } i2c_mst_state_e;

    // clk cycles per quarter bit period (100 kHz SCL from a 100 MHz clk)
    localparam int I2C_CLK_DIV_DEFAULT = 250;

    // Bit slots from accept to the done pulse, full transfer and address NACK
    localparam int I2C_SLOTS_FULL      = 20;
    localparam int I2C_SLOTS_ADDR_NACK = 11;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period timer for one I2C bit slot, with SCL clock-stretch hold.
module i2c_bit_timer #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       scl_i,
    output logic [1:0] phase,
    output logic       sample_stb,
    output logic       slot_end
);

    localparam int            QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

    logic [QW-1:0] qcnt;
    logic          q_last;
    logic          stretch_hold;

    assign q_last = (qcnt == QLAST);

    // A slave holding SCL low after we released it freezes the slot in q2
    assign stretch_hold = (phase == 2'd2) && !scl_i;

    assign sample_stb = run && (phase == 2'd2) && q_last && !stretch_hold;
    assign slot_end   = run && (phase == 2'd3) && q_last;

    // Quarter counter and phase; cleared whenever the sequencer is not running
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            qcnt  <= '0;
            phase <= 2'd0;
        end else if (!stretch_hold) begin
            if (q_last) begin
                qcnt  <= '0;
                phase <= phase + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP.
module i2c_master_controller
    import iot_sensor_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_read,
    input  logic [6:0] slave_addr,
    input  logic       read_write_n,
    input  logic [7:0] write_data,
    output logic [7:0] i2c_read_data,
    output logic       transaction_done,
    output logic       ack_error,
    output logic       busy,
    output logic       scl_oe,
    input  logic       scl_i,
    output logic       sda_oe,
    input  logic       sda_i
);

    i2c_mst_state_e state_q, state_d;

    logic [1:0] phase;
    logic       sample_stb;
    logic       slot_end;
    logic       run;
    logic       accept;

    logic [2:0] bit_cnt;
    logic       err_q;
    logic [7:0] rd_data_q;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [7:0] wdata_q;
    logic       rw_q;

    assign accept = (state_q == IDLE) && start_read;
    assign run    = (state_q != IDLE) && (state_q != DONE);

    i2c_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .scl_i      (scl_i),
        .phase      (phase),
        .sample_stb (sample_stb),
        .slot_end   (slot_end)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance on slot boundaries, byte states run for 8 slots
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_read) state_d = START;
            START:    if (slot_end) state_d = ADDR;
            ADDR:     if (slot_end && bit_cnt == 3'd7) state_d = ADDR_ACK;
            ADDR_ACK: if (slot_end) state_d = err_q ? STOP : (rw_q ? RD_DATA : WR_DATA);
            WR_DATA:  if (slot_end && bit_cnt == 3'd7) state_d = WR_ACK;
            WR_ACK:   if (slot_end) state_d = STOP;
            RD_DATA:  if (slot_end && bit_cnt == 3'd7) state_d = RD_NACK;
            RD_NACK:  if (slot_end) state_d = STOP;
            STOP:     if (slot_end) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus drive: SCL low in q0/q1 of clocked slots; START/STOP shape SDA around high SCL
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            START: begin
                sda_oe = phase[1];
            end
            ADDR, WR_DATA: begin
                scl_oe = ~phase[1];
                sda_oe = ~tx_sr[7];
            end
            ADDR_ACK, WR_ACK, RD_DATA, RD_NACK: begin
                scl_oe = ~phase[1];
            end
            STOP: begin
                scl_oe = ~phase[1];
                sda_oe = (phase != 2'd3);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // Bit counter, NACK flag and the externally visible read byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            err_q     <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            if (accept) begin
                bit_cnt <= 3'd0;
                err_q   <= 1'b0;
            end
            if (slot_end && (state_q == ADDR || state_q == WR_DATA || state_q == RD_DATA)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (sample_stb && (state_q == ADDR_ACK || state_q == WR_ACK) && sda_i) begin
                err_q <= 1'b1;
            end
            if (slot_end && state_q == STOP && rw_q && !err_q) begin
                rd_data_q <= rx_sr;
            end
        end
    end

    // Request latch and shift registers; contents only matter inside a transaction
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sr   <= {slave_addr, read_write_n};
            rw_q    <= read_write_n;
            wdata_q <= write_data;
        end else if (slot_end && (state_q == ADDR || state_q == WR_DATA)) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end else if (slot_end && state_q == ADDR_ACK) begin
            tx_sr <= wdata_q;
        end
        if (sample_stb && state_q == RD_DATA) begin
            rx_sr <= {rx_sr[6:0], sda_i};
        end
    end

    assign i2c_read_data    = rd_data_q;
    assign transaction_done = (state_q == DONE);
    assign ack_error        = (state_q == DONE) && err_q;
    assign busy             = rst_n && ((state_q != IDLE) || start_read);

endmodule

// File: tb/tb_i2c_master_controller.sv
// Self-checking bench: open-drain bus with a behavioural I2C slave.
module tb_i2c_master_controller;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_read = 1'b0;
    logic [6:0] slave_addr = 7'h00;
    logic       read_write_n = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic [7:0] i2c_read_data;
    logic       transaction_done;
    logic       ack_error;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_i;
    logic       sda_i;

    // Slave configuration (set by the stimulus before each transfer)
    logic       slv_present = 1'b1;
    logic [7:0] slv_rdata = 8'h00;
    logic       slv_wack = 1'b1;
    int         slv_stretch = 0;

    // Slave-side drivers and bus observations
    logic       slv_scl_low = 1'b0;
    logic       slv_sda_low = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         fall_n = 0;
    int         rise_n = 0;
    int         st_cnt = 0;
    int         last_rises = 0;
    int         mon_starts = 0;
    int         mon_stops = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    logic [7:0] mon_addr = 8'h00;
    logic [7:0] mon_data = 8'h00;
    logic       mon_mack = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    assign scl_i = ~(scl_oe | slv_scl_low);
    assign sda_i = ~(sda_oe | slv_sda_low);

    always #5 clk = ~clk;

    i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_read       (start_read),
        .slave_addr       (slave_addr),
        .read_write_n     (read_write_n),
        .write_data       (write_data),
        .i2c_read_data    (i2c_read_data),
        .transaction_done (transaction_done),
        .ack_error        (ack_error),
        .busy             (busy),
        .scl_oe           (scl_oe),
        .scl_i            (scl_i),
        .sda_oe           (sda_oe),
        .sda_i            (sda_i)
    );

    // What the slave pulls SDA to during bit slot n (0..7 addr, 8 ack, 9..16 data, 17 ack)
    function automatic logic slave_drive(input int n);
        if (!slv_present) return 1'b0;
        if (n == 8) return 1'b1;
        if (mon_addr[0] && n >= 9 && n <= 16) return !slv_rdata[16 - n];
        if (!mon_addr[0] && n == 17) return slv_wack;
        return 1'b0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (transaction_done) done_cnt <= done_cnt + 1;

    // Behavioural slave: decodes START/STOP and bits from bus edges
    always @(posedge clk) begin
        prev_scl <= scl_i;
        prev_sda <= sda_i;
        if (prev_scl && scl_i && prev_sda && !sda_i) begin
            mon_starts <= mon_starts + 1;
            fall_n     <= 0;
            rise_n     <= 0;
        end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
            mon_stops   <= mon_stops + 1;
            last_rises  <= rise_n;
            slv_sda_low <= 1'b0;
        end
        if (prev_scl && !scl_i) begin
            fall_n      <= fall_n + 1;
            slv_sda_low <= slave_drive(fall_n);
            if (fall_n == 12 && slv_stretch > 0) begin
                slv_scl_low <= 1'b1;
                st_cnt      <= 0;
            end
        end
        if (!prev_scl && scl_i) begin
            rise_n <= rise_n + 1;
            if (rise_n < 8) mon_addr <= {mon_addr[6:0], sda_i};
            else if (rise_n >= 9 && rise_n <= 16) mon_data <= {mon_data[6:0], sda_i};
            else if (rise_n == 17) mon_mack <= sda_i;
        end
        if (slv_scl_low && !scl_oe) begin
            if (st_cnt + 1 >= slv_stretch) slv_scl_low <= 1'b0;
            st_cnt <= st_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (transaction_done) got = 1'b1;
        end
    endtask

    // One complete transfer with latency, result and bus-level checks
    task automatic run_txn(input string nm, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input int exp_lat, input logic exp_err,
                           input logic [7:0] exp_rd, input int exp_rises, input int pulse_at);
        int acc, lat, st0, sp0, d0;
        bit got;
        @(negedge clk);
        st0 = mon_starts;
        sp0 = mon_stops;
        d0  = done_cnt;
        slave_addr   = a;
        read_write_n = rw;
        write_data   = wd;
        start_read   = 1'b1;
        #1 chk({nm, " busy_on_accept"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        start_read   = 1'b0;
        slave_addr   = 7'($urandom);
        write_data   = 8'($urandom);
        read_write_n = 1'($urandom);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 3000 && !got; i++) begin
            @(negedge clk);
            start_read = (i == pulse_at);
            if (transaction_done) begin
                got = 1'b1;
                lat = cyc - acc;
            end
        end
        start_read = 1'b0;
        chk({nm, " done_seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " ack_error"}, 32'(ack_error), 32'(exp_err));
        chk({nm, " busy_at_done"}, 32'(busy), 32'd1);
        chk({nm, " read_data"}, 32'(i2c_read_data), 32'(exp_rd));
        @(negedge clk);
        chk({nm, " done_pulse_width"}, 32'(transaction_done), 32'd0);
        chk({nm, " busy_after"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk({nm, " start_count"}, 32'(mon_starts - st0), 32'd1);
        chk({nm, " stop_count"}, 32'(mon_stops - sp0), 32'd1);
        chk({nm, " done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({nm, " scl_clocks"}, 32'(last_rises), 32'(exp_rises));
        chk({nm, " addr_byte"}, 32'(mon_addr), 32'({a, rw}));
        if (slv_present && !rw) chk({nm, " write_byte"}, 32'(mon_data), 32'(wd));
        if (slv_present && rw) chk({nm, " master_nack"}, 32'(mon_mack), 32'd1);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wd;
        logic       present;
        logic [7:0] srd;
        logic       wack;
        int         stretch;
        int         lat;
        logic       err;
        logic [7:0] rd;
        int         rises;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timed out");
    end

    initial begin
        logic [7:0] model_rd;
        bit         got;
        bit         found;
        int         d0, st0;

        tbl[0] = '{7'h40, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b1, 0,  320, 1'b0, 8'hA5, 19};
        tbl[1] = '{7'h48, 1'b0, 8'h3C, 1'b1, 8'h00, 1'b1, 0,  320, 1'b0, 8'hA5, 19};
        tbl[2] = '{7'h41, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 0,  176, 1'b1, 8'hA5, 10};
        tbl[3] = '{7'h48, 1'b0, 8'h77, 1'b1, 8'h00, 1'b0, 0,  320, 1'b1, 8'hA5, 19};
        tbl[4] = '{7'h40, 1'b1, 8'h00, 1'b1, 8'h5A, 1'b1, 37, 357, 1'b0, 8'h5A, 19};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset scl_oe", 32'(scl_oe), 32'd0);
        chk("reset sda_oe", 32'(sda_oe), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(transaction_done), 32'd0);
        chk("reset ack_error", 32'(ack_error), 32'd0);
        chk("reset read_data", 32'(i2c_read_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            slv_present = tbl[i].present;
            slv_rdata   = tbl[i].srd;
            slv_wack    = tbl[i].wack;
            slv_stretch = tbl[i].stretch;
            run_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rw, tbl[i].wd,
                    tbl[i].lat, tbl[i].err, tbl[i].rd, tbl[i].rises, 0);
        end

        // Randomised transfers against a slot-count reference model
        model_rd = 8'h5A;
        for (int i = 0; i < 25; i++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] wd;
            int         lat;
            logic       err;
            a           = 7'($urandom);
            rw          = 1'($urandom);
            wd          = 8'($urandom);
            slv_present = ($urandom_range(0, 3) != 0);
            slv_rdata   = 8'($urandom);
            slv_wack    = ($urandom_range(0, 3) != 0);
            slv_stretch = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
            err = !slv_present || (!rw && !slv_wack);
            lat = slv_present ? (20 * 4 * CLK_DIV + slv_stretch) : (11 * 4 * CLK_DIV);
            if (rw && slv_present) model_rd = slv_rdata;
            run_txn($sformatf("rnd%0d", i), a, rw, wd, lat, err, model_rd,
                    slv_present ? 19 : 10, 0);
        end

        // Request pulsed mid-transfer is ignored
        slv_present = 1'b1;
        slv_wack    = 1'b1;
        slv_stretch = 0;
        d0 = done_cnt;
        run_txn("busy_pulse", 7'h22, 1'b0, 8'hC3, 320, 1'b0, model_rd, 19, 100);
        repeat (400) @(negedge clk);
        chk("busy_pulse total_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_pulse idle", 32'(busy), 32'd0);

        // Request held through done restarts on the following cycle
        d0  = done_cnt;
        st0 = mon_starts;
        @(negedge clk);
        slave_addr   = 7'h33;
        read_write_n = 1'b0;
        write_data   = 8'h0F;
        start_read   = 1'b1;
        wait_done(got);
        chk("held first_done", 32'(got), 32'd1);
        @(negedge clk);
        chk("held restart_busy", 32'(busy), 32'd1);
        chk("held no_double_done", 32'(transaction_done), 32'd0);
        @(posedge clk);
        #1 start_read = 1'b0;
        chk("held busy_in_second", 32'(busy), 32'd1);
        wait_done(got);
        chk("held second_done", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        chk("held done_count", 32'(done_cnt - d0), 32'd2);
        chk("held start_count", 32'(mon_starts - st0), 32'd2);

        // Reset during the address byte
        @(negedge clk);
        slave_addr   = 7'h00;
        read_write_n = 1'b0;
        write_data   = 8'h00;
        start_read   = 1'b1;
        @(posedge clk);
        #1 start_read = 1'b0;
        repeat (48) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (scl_oe) found = 1'b1;
        end
        chk("midrst scl_driven", 32'(scl_oe), 32'd1);
        chk("midrst sda_driven", 32'(sda_oe), 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst scl_oe", 32'(scl_oe), 32'd0);
        chk("midrst sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(transaction_done), 32'd0);
        chk("midrst read_data", 32'(i2c_read_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("midrst no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
- Single-byte I2C master that services transaction requests from the sensor interface blocks: start_read, slave_addr, read_write_n and write_data in; i2c_read_data, transaction_done and ack_error out.
- Generates START, the 7-bit address plus R/W bit, one data byte (write, or read with master NACK) and STOP on open-drain SCL/SDA.
- Honours slave clock stretching.
- Sits between the sensor interfaces (through the bus arbiter) and the chip pads.

Parameters:
- CLK_DIV, 250, clk cycles per quarter bit period; 250 gives 100 kHz SCL at 100 MHz clk; legal minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start_read  input  1  transaction request; sampled only in IDLE
- slave_addr  input  7  target address; latched on accept
- read_write_n  input  1  1 = read, 0 = write; latched on accept
- write_data  input  8  byte to write; latched on accept
- i2c_read_data  output  8  received byte; held until the next successful read
- transaction_done  output  1  one-cycle pulse at the end of every transaction
- ack_error  output  1  valid with transaction_done; 1 = slave NACK
- busy  output  1  high from the accept cycle until the done pulse, inclusive
- scl_oe  output  1  1 = pull SCL low, 0 = release
- scl_i  input  1  sampled SCL pad (for stretching)
- sda_oe  output  1  1 = pull SDA low, 0 = release
- sda_i  input  1  sampled SDA pad

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low. While rst_n is low, on every clk edge: scl_oe=0, sda_oe=0, busy=0, transaction_done=0, ack_error=0, i2c_read_data=0x00, state=IDLE.
- Reset mid-transaction: both lines are released on the next edge and no done pulse is produced.
- Accept:
  - In IDLE with start_read=1, latch addr, rw and data; busy=1 in the same cycle.
  - start_read is ignored while busy.
  - A request held high through the done cycle starts a new transaction on the cycle after done.
- Bit slot: 4 quarters of CLK_DIV cycles each.
  - q0 and q1: SCL low. SDA is updated at the start of q0.
  - q2 and q3: SCL released.
  - SDA is sampled on the last cycle of q2.
  - Stretching: while in q2 with scl_i=0, the quarter counter holds.
- States: IDLE -> START -> ADDR(8) -> ADDR_ACK -> {WR_DATA(8) -> WR_ACK | RD_DATA(8) -> RD_NACK} -> STOP -> DONE -> IDLE.
- START: SDA released in q0 and q1, pulled low in q2 and q3, with SCL released throughout.
- ADDR: sends {addr, rw} MSB first.
- ADDR_ACK, WR_ACK: SDA released. sda_i=1 at the sample point is a NACK; set the internal error flag.
- A NACK in ADDR_ACK jumps straight to STOP, skipping the data byte.
- RD_DATA: shift in sda_i MSB first. RD_NACK: master releases SDA (NACK).
- STOP: SCL low in q0 and q1 with SDA low; SCL released in q2 with SDA low; SDA released in q3.
- DONE: one cycle.
  - transaction_done=1; ack_error = error flag; busy=1; lines released.
  - On a read without error, i2c_read_data updates in this same cycle.
  - A failed read leaves i2c_read_data unchanged.
- Latency (no stretching): transaction_done rises exactly 80*CLK_DIV cycles after the accept edge (20 slots). For an address NACK it is 44*CLK_DIV cycles (11 slots).
- SDA changes only while SCL is low, except at START and STOP.
- An arbitration or bus-busy check is not performed; the external arbiter guarantees a single master.

Decomposition:
- iot_sensor_pkg gains:
  - i2c_mst_state_e (the states above)
  - I2C_CLK_DIV_DEFAULT = 250
  - I2C_SLOTS_FULL = 20
  - I2C_SLOTS_ADDR_NACK = 11
- Sub-module i2c_bit_timer: quarter counter of width $clog2(CLK_DIV) plus a 2-bit phase. Outputs phase, the q2 sample strobe and the end-of-slot strobe, and applies the stretch hold.
- i2c_master_controller holds the FSM, shift registers and bit counter.

Test Plan (CLK_DIV=4, bench open-drain slave model):
1. Read from 0x40, slave ACKs and returns 0xA5 -> bus byte 0x81; master NACKs the data byte; done at 320 cycles after accept; i2c_read_data=0xA5; ack_error=0.
2. Write 0x3C to 0x48, slave ACKs both bytes -> bus bytes 0x90 then 0x3C; done at 320 cycles; ack_error=0; i2c_read_data unchanged.
3. Read from 0x41 with no slave present -> done at 176 cycles; ack_error=1; no data clocks; STOP seen; i2c_read_data still 0xA5.
4. Write, slave NACKs the data byte -> ack_error=1 at 320 cycles; STOP issued.
5. Read 0x5A, slave holds SCL low 37 cycles at data bit 3 -> done at 357 cycles; i2c_read_data=0x5A.
6. Pulse start_read again while busy -> ignored, exactly one transaction. Assert rst_n=0 during the address byte -> next edge scl_oe=sda_oe=0, busy=0, no transaction_done.
